ibex_run_ctrl: RTL and testbench



---
 rtl/ibex_run_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ibex_run_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_run_ctrl.sv
// Run-control stage for an Ibex core: boot delay, run watchdog, drain wait,
// sticky pass/fail/timeout result and bounded debug-request pulses.
module ibex_run_ctrl #(
  parameter int unsigned BOOT_DELAY    = 16,
  parameter int unsigned DBG_PULSE_LEN = 4,
  parameter int unsigned RUN_TIMEOUT   = 100000,
  parameter int unsigned DRAIN_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       dbg_trigger_i,
  input  logic       core_sleep_i,
  input  logic       alert_minor_i,
  input  logic       alert_major_i,
  input  logic       ecall_i,
  output logic       fetch_enable_o,
  output logic       debug_req_o,
  output logic       done_o,
  output logic [1:0] status_o,
  output logic [7:0] minor_alert_cnt_o
);

  localparam int unsigned BootW  = $clog2(BOOT_DELAY + 2);
  localparam int unsigned RunW   = $clog2(RUN_TIMEOUT + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned PulseW = $clog2(DBG_PULSE_LEN + 1);

  localparam logic [BootW-1:0]  BootLoad  = BootW'(BOOT_DELAY);
  localparam logic [RunW-1:0]   RunLast   = RunW'(RUN_TIMEOUT - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_TIMEOUT - 1);
  localparam logic [PulseW-1:0] PulseLoad = PulseW'(DBG_PULSE_LEN - 1);

  localparam logic [1:0] StatPass    = 2'b01;
  localparam logic [1:0] StatFail    = 2'b10;
  localparam logic [1:0] StatTimeout = 2'b11;

  typedef enum logic [2:0] {StIdle, StBoot, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic              fetch_q, fetch_d;
  logic              dbg_q, dbg_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [7:0]        minor_q, minor_d;
  logic [BootW-1:0]  boot_cnt_q, boot_cnt_d;
  logic [RunW-1:0]   run_cnt_q, run_cnt_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic [PulseW-1:0] pulse_cnt_q, pulse_cnt_d;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    boot_cnt_d  = boot_cnt_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    dbg_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (BOOT_DELAY == 0) begin
            state_d   = StRun;
            run_cnt_d = '0;
          end else begin
            state_d    = StBoot;
            boot_cnt_d = BootLoad;
          end
        end
      end
      StBoot: begin
        if (boot_cnt_q == '0) begin
          state_d   = StRun;
          run_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q - 1'b1;
        end
      end
      StRun: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // Any exit from RUN leaves dbg_d at its default, aborting a live pulse.
        if (alert_major_i) begin
          state_d  = StDone;
          status_d = StatFail;
        end else if (ecall_i) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end else if (run_cnt_q == RunLast) begin
          state_d  = StDone;
          status_d = StatTimeout;
        end else if (dbg_q) begin
          // Triggers during a pulse, including its last cycle, are dropped.
          if (pulse_cnt_q != '0) begin
            dbg_d       = 1'b1;
            pulse_cnt_d = pulse_cnt_q - 1'b1;
          end
        end else if (dbg_trigger_i) begin
          dbg_d       = 1'b1;
          pulse_cnt_d = PulseLoad;
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (alert_major_i) begin
          state_d  = StDone;
          status_d = StatFail;
        end else if (core_sleep_i) begin
          state_d  = StDone;
          status_d = StatPass;
        end else if (drain_cnt_q == DrainLast) begin
          state_d  = StDone;
          status_d = StatTimeout;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    fetch_d = (state_d == StRun);
    done_d  = (state_d == StDone);
    minor_d = (alert_minor_i && (minor_q != 8'hFF)) ? minor_q + 8'd1 : minor_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      fetch_q     <= 1'b0;
      dbg_q       <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 2'b00;
      minor_q     <= 8'd0;
      boot_cnt_q  <= '0;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_q     <= fetch_d;
      dbg_q       <= dbg_d;
      done_q      <= done_d;
      status_q    <= status_d;
      minor_q     <= minor_d;
      boot_cnt_q  <= boot_cnt_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign fetch_enable_o    = fetch_q;
  assign debug_req_o       = dbg_q;
  assign done_o            = done_q;
  assign status_o          = status_q;
  assign minor_alert_cnt_o = minor_q;

endmodule

// File: tb/tb_ibex_run_ctrl.sv
// Bench for ibex_run_ctrl: directed vector table plus randomized stimulus
// checked every cycle against a timestamp-based reference model.
module tb_ibex_run_ctrl;

  localparam int unsigned BootDelay = 16;
  localparam int unsigned PulseLen  = 4;
  localparam int unsigned RunTo     = 50;
  localparam int unsigned DrainTo   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, trig = 1'b0, sleep = 1'b0;
  logic       minor = 1'b0, major = 1'b0, ecall = 1'b0;
  logic       fetch_enable, debug_req, done;
  logic [1:0] status;
  logic [7:0] minor_cnt;

  int checks = 0;
  int errors = 0;

  ibex_run_ctrl #(
    .BOOT_DELAY   (BootDelay),
    .DBG_PULSE_LEN(PulseLen),
    .RUN_TIMEOUT  (RunTo),
    .DRAIN_TIMEOUT(DrainTo)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .dbg_trigger_i    (trig),
    .core_sleep_i     (sleep),
    .alert_minor_i    (minor),
    .alert_major_i    (major),
    .ecall_i          (ecall),
    .fetch_enable_o   (fetch_enable),
    .debug_req_o      (debug_req),
    .done_o           (done),
    .status_o         (status),
    .minor_alert_cnt_o(minor_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, start, trig, sleep, minor, major, ecall;
  } in_t;

  typedef struct {
    in_t        in;
    int         n;
    logic       fe, dr, dn;
    logic [1:0] st;
    logic [7:0] mc;
  } vec_t;

  vec_t tbl[$];

  // Reference model: phases plus absolute edge timestamps.
  typedef enum int {PIdle, PBoot, PRun, PDrain, PDone} phase_e;
  phase_e     m_phase = PIdle;
  int         t = 0;
  int         run_start = 0, drain_start = 0, pulse_until = 0;
  logic [1:0] m_status = 2'b00;
  int         m_minor = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  task automatic model_edge(input in_t i);
    t++;
    if (i.rst) begin
      m_phase = PIdle; m_status = 2'b00; m_minor = 0; pulse_until = 0;
      return;
    end
    if (i.minor && m_minor < 255) m_minor++;
    case (m_phase)
      PIdle: if (i.start) begin
        run_start = t + BootDelay + 1;
        m_phase   = PBoot;
      end
      PBoot: if (t == run_start) m_phase = PRun;
      PRun: begin
        if (i.major) begin
          m_phase = PDone; m_status = 2'b10;
        end else if (i.ecall) begin
          m_phase = PDrain; drain_start = t;
        end else if (t - run_start == RunTo) begin
          m_phase = PDone; m_status = 2'b11;
        end else if (i.trig && t > pulse_until) begin
          pulse_until = t + PulseLen;
        end
      end
      PDrain: begin
        if (i.major) begin
          m_phase = PDone; m_status = 2'b10;
        end else if (i.sleep) begin
          m_phase = PDone; m_status = 2'b01;
        end else if (t - drain_start == DrainTo) begin
          m_phase = PDone; m_status = 2'b11;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input in_t i);
    rst = i.rst; start = i.start; trig = i.trig; sleep = i.sleep;
    minor = i.minor; major = i.major; ecall = i.ecall;
    @(posedge clk);
    model_edge(i);
    #1;
    chk("model fetch_enable", int'(fetch_enable), int'(m_phase == PRun));
    chk("model debug_req", int'(debug_req), int'(m_phase == PRun && t < pulse_until));
    chk("model done", int'(done), int'(m_phase == PDone));
    chk("model status", int'(status), int'(m_phase == PDone ? m_status : 2'b00));
    chk("model minor_cnt", int'(minor_cnt), m_minor);
  endtask

  function automatic void add(input logic r, s, tg, sl, mi, ma, ec, input int n,
                              input logic fe, dr, dn, input logic [1:0] st,
                              input logic [7:0] mc);
    vec_t v;
    v.in = '{rst: r, start: s, trig: tg, sleep: sl, minor: mi, major: ma, ecall: ec};
    v.n = n; v.fe = fe; v.dr = dr; v.dn = dn; v.st = st; v.mc = mc;
    tbl.push_back(v);
  endfunction

  // Reset, start pulse and full boot; leaves the DUT on its first RUN cycle.
  function automatic void add_boot();
    add(1, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 2'd0, 8'd0);
    add(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 16, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2'd0, 8'd0);
  endfunction

  initial begin
    in_t ri;

    // Boot, debug pulses, ecall abort, drain to PASS, sticky result.
    add_boot();
    add(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 2'd0, 8'd0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 8'd0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 8'd0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 8'd0);
    add(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 2'd1, 8'd0);
    add(0, 1, 1, 1, 1, 1, 1, 3, 0, 0, 1, 2'd1, 8'd3);
    add(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 2'd1, 8'd3);
    // Major alert beats ecall in RUN.
    add_boot();
    add(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 2'd2, 8'd0);
    add(0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 1, 2'd2, 8'd0);
    // Major alert beats core_sleep in DRAIN.
    add_boot();
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 2'd2, 8'd0);
    // Run watchdog timeout.
    add_boot();
    add(0, 0, 0, 0, 0, 0, 0, RunTo - 1, 1, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0);
    // Drain timeout.
    add_boot();
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, DrainTo - 1, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2'd3, 8'd0);
    // Reset mid-RUN with a pulse active, then a fresh boot.
    add_boot();
    add(0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 2'd0, 8'd1);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 16, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 8'd0);
    // Minor-alert saturation.
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0);
    add(0, 0, 0, 0, 1, 0, 0, 254, 0, 0, 0, 2'd0, 8'd254);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'd0, 8'd255);
    add(0, 0, 0, 0, 1, 0, 0, 45, 0, 0, 0, 2'd0, 8'd255);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'd255);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 8'd0);

    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].n; c++) step(tbl[k].in);
      chk($sformatf("vec%0d fetch_enable", k), int'(fetch_enable), int'(tbl[k].fe));
      chk($sformatf("vec%0d debug_req", k), int'(debug_req), int'(tbl[k].dr));
      chk($sformatf("vec%0d done", k), int'(done), int'(tbl[k].dn));
      chk($sformatf("vec%0d status", k), int'(status), int'(tbl[k].st));
      chk($sformatf("vec%0d minor_cnt", k), int'(minor_cnt), int'(tbl[k].mc));
    end

    // Randomized traffic; the model checks every cycle inside step().
    for (int c = 0; c < 6000; c++) begin
      ri.rst   = ($urandom_range(149) == 0);
      ri.start = ($urandom_range(3) == 0);
      ri.trig  = ($urandom_range(2) == 0);
      ri.sleep = ($urandom_range(7) == 0);
      ri.minor = ($urandom_range(1) == 0);
      ri.major = ($urandom_range(59) == 0);
      ri.ecall = ($urandom_range(24) == 0);
      step(ri);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
